// File: rtl/div_exec_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with a fixed grant-to-result latency.
// Restoring division resolves BITS_PER_CYCLE quotient bits per cycle; sign fix-up and special cases are applied on the final edge.
module div_exec_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 7,
  parameter int ITER           = 5,
  parameter int DIV_LATENCY    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            q_valid,
  input  logic [1:0]      q_op,
  input  logic [XLEN-1:0] q_rs1,
  input  logic [XLEN-1:0] q_rs2,
  input  logic [5:0]      q_tag,
  input  logic            grant,
  output logic            div_ready,
  output logic            div_busy,
  output logic [XLEN-1:0] div_result,
  output logic [5:0]      div_tag
);

  localparam int CNT_W      = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int LAST_STEPS = XLEN - (ITER - 1) * BITS_PER_CYCLE;

  if (ITER != (XLEN + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE) begin : g_bad_iter
    $error("div_exec_unit: ITER must equal ceil(XLEN/BITS_PER_CYCLE)");
  end
  if (DIV_LATENCY != 6 || DIV_LATENCY != ITER + 1) begin : g_bad_lat
    $error("div_exec_unit: DIV_LATENCY must be 6 and equal ITER+1");
  end

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  iter_cnt_q, iter_cnt_d;
  logic [1:0]        op_q;
  logic [5:0]        tag_q;
  logic [XLEN-1:0]   quo_q, dvs_q, rem_q;
  logic              qsign_q, rsign_q, div0_q, ovf_q;
  logic [XLEN-1:0]   div_result_q, div_tag_q_unused;
  logic [5:0]        div_tag_q;

  logic              start, last, sgn_op;
  logic [XLEN:0]     rem_w;
  logic [XLEN-1:0]   quo_w, res_w, quo_fix, rem_fix;
  logic signed [XLEN-1:0] int_min;
  int                steps_w;

  assign div_tag_q_unused = '0;
  assign int_min = {1'b1, {(XLEN-1){1'b0}}};
  assign start   = grant & q_valid & ~div_busy;
  assign last    = (state_q == CALC) && (iter_cnt_q == CNT_W'(ITER - 1));
  assign sgn_op  = ~q_op[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = CALC;
        iter_cnt_d = '0;
      end
      CALC: if (last) begin
        state_d    = IDLE;
        iter_cnt_d = '0;
      end else begin
        iter_cnt_d = iter_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_busy = (state_q == CALC);
  end

  // Restoring steps for this cycle: quotient bits shift into quo as dividend bits shift out MSB first.
  always_comb begin
    steps_w = last ? LAST_STEPS : BITS_PER_CYCLE;
    rem_w   = {1'b0, rem_q};
    quo_w   = quo_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (k < steps_w) begin
        rem_w = {rem_w[XLEN-1:0], quo_w[XLEN-1]};
        quo_w = {quo_w[XLEN-2:0], 1'b0};
        if (rem_w >= {1'b0, dvs_q}) begin
          rem_w    = rem_w - {1'b0, dvs_q};
          quo_w[0] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    quo_fix = div0_q ? '1 : neg_if(quo_w, qsign_q);
    rem_fix = neg_if(rem_w[XLEN-1:0], rsign_q);
    if (ovf_q) begin
      quo_fix = int_min;
      rem_fix = '0;
    end
    res_w = op_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      tag_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      qsign_q      <= 1'b0;
      rsign_q      <= 1'b0;
      div0_q       <= 1'b0;
      ovf_q        <= 1'b0;
      div_result_q <= '0;
      div_tag_q    <= '0;
    end else if (start) begin
      op_q    <= q_op;
      tag_q   <= q_tag;
      quo_q   <= abs_val(q_rs1, sgn_op);
      dvs_q   <= abs_val(q_rs2, sgn_op);
      rem_q   <= '0;
      qsign_q <= sgn_op & (q_rs1[XLEN-1] ^ q_rs2[XLEN-1]);
      rsign_q <= sgn_op & q_rs1[XLEN-1];
      div0_q  <= (q_rs2 == '0);
      ovf_q   <= sgn_op && (q_rs1 == int_min) && (q_rs2 == '1);
    end else if (state_q == CALC) begin
      quo_q <= quo_w;
      rem_q <= rem_w[XLEN-1:0];
      if (last) begin
        div_result_q <= res_w;
        div_tag_q    <= tag_q;
      end
    end
  end

  assign div_ready  = q_valid;
  assign div_result = div_result_q | div_tag_q_unused;
  assign div_tag    = div_tag_q;

endmodule

// File: tb/tb_div_exec_unit.sv
// Bench for div_exec_unit: directed vector table, hand-written timing sequences and randomized ops against an arithmetic model.
module tb_div_exec_unit;

  logic        clk, rst, q_valid, grant;
  logic [1:0]  q_op;
  logic [31:0] q_rs1, q_rs2;
  logic [5:0]  q_tag;
  logic        div_ready, div_busy;
  logic [31:0] div_result;
  logic [5:0]  div_tag;

  int checks = 0;
  int failures = 0;

  div_exec_unit dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_op(q_op), .q_rs1(q_rs1),
    .q_rs2(q_rs2), .q_tag(q_tag), .grant(grant), .div_ready(div_ready),
    .div_busy(div_busy), .div_result(div_result), .div_tag(div_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    bit is_rem = op[1];
    bit is_sgn = !op[0];
    sa = a;
    sb = b;
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
    if (is_sgn) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? a % b : a / b;
  endfunction

  // Called at a falling edge (cycle T); returns at the falling edge in T+6.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag, input bit chk_busy,
                        output logic [31:0] res, output logic [5:0] rtag);
    q_valid = 1'b1; grant = 1'b1; q_op = op; q_rs1 = a; q_rs2 = b; q_tag = tag;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        grant = 1'b0; q_valid = 1'b0; q_rs1 = $urandom; q_rs2 = $urandom; q_tag = 6'($urandom);
      end
      if (chk_busy) chk($sformatf("busy_T+%0d", k), 32'(div_busy), (k < 6) ? 32'd1 : 32'd0);
    end
    res = div_result;
    rtag = div_tag;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  vec_t vecs[$];
  logic [31:0] res;
  logic [5:0]  rtag;

  initial begin
    rst = 1'b1; q_valid = 1'b0; grant = 1'b0; q_op = 2'b00; q_rs1 = '0; q_rs2 = '0; q_tag = '0;
    vecs.push_back('{2'b01, 32'd100,        32'd7,          6'd5,  32'd14});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          6'd6,  32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          6'd7,  32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'd16,         6'd8,  32'd15});
    vecs.push_back('{2'b00, 32'd1234,       32'd0,          6'd9,  32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'd1234,       32'd0,          6'd10, 32'd1234});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  6'd11, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  6'd12, 32'h0});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  6'd13, 32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  6'd14, 32'd1});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  6'd15, 32'd0});
    vecs.push_back('{2'b11, 32'd5,          32'd0,          6'd16, 32'd5});
    vecs.push_back('{2'b10, 32'hFFFF_FFF8,  32'd4,          6'd17, 32'd0});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'd1,          6'd63, 32'h8000_0000});

    @(negedge clk); @(negedge clk);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_result", div_result, 32'd0);
    chk("rst_tag", 32'(div_tag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    q_valid = 1'b1;
    #1 chk("ready_pass", 32'(div_ready), 32'd1);
    q_valid = 1'b0;
    #1 chk("ready_pass_lo", 32'(div_ready), 32'd0);
    grant = 1'b1;
    @(negedge clk);
    chk("grant_no_valid_busy", 32'(div_busy), 32'd0);
    grant = 1'b0;

    foreach (vecs[i]) begin
      do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, (i == 0), res, rtag);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), 32'(rtag), 32'(vecs[i].tag));
    end

    // Back-to-back with an ignored grant pulse mid-divide.
    q_valid = 1'b1; grant = 1'b1; q_op = 2'b01; q_rs1 = 32'd50; q_rs2 = 32'd5; q_tag = 6'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      grant = 1'b0; q_valid = 1'b0;
      if (k == 3) begin
        q_valid = 1'b1; grant = 1'b1; q_op = 2'b11; q_rs1 = 32'd99; q_rs2 = 32'd4; q_tag = 6'd33;
      end
    end
    chk("b2b_t1_result", div_result, 32'd10);
    chk("b2b_t1_tag", 32'(div_tag), 32'd1);
    chk("b2b_T6_busy", 32'(div_busy), 32'd0);
    q_valid = 1'b1; grant = 1'b1; q_op = 2'b01; q_rs1 = 32'd81; q_rs2 = 32'd9; q_tag = 6'd2;
    @(negedge clk);
    grant = 1'b0; q_valid = 1'b0;
    chk("b2b_hold_result", div_result, 32'd10);
    chk("b2b_hold_tag", 32'(div_tag), 32'd1);
    chk("b2b_t2_busy", 32'(div_busy), 32'd1);
    repeat (5) @(negedge clk);
    chk("b2b_t2_result", div_result, 32'd9);
    chk("b2b_t2_tag", 32'(div_tag), 32'd2);

    // Reset in the middle of a divide.
    q_valid = 1'b1; grant = 1'b1; q_op = 2'b01; q_rs1 = 32'd100; q_rs2 = 32'd3; q_tag = 6'd7;
    @(negedge clk);
    grant = 1'b0; q_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_result", div_result, 32'd0);
    chk("midrst_tag", 32'(div_tag), 32'd0);
    chk("midrst_busy", 32'(div_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_T6_result", div_result, 32'd0);
    chk("midrst_T6_busy", 32'(div_busy), 32'd0);
    @(negedge clk);
    chk("midrst_T7_tag", 32'(div_tag), 32'd0);
    do_div(2'b00, 32'hFFFF_FF9C, 32'd7, 6'd44, 1'b1, res, rtag);
    chk("postrst_result", res, 32'hFFFF_FFF2);
    chk("postrst_tag", 32'(rtag), 32'd44);

    for (int i = 0; i < 10000; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [5:0]  tag;
      op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      tag = 6'(i);
      do_div(op, a, b, tag, 1'b0, res, rtag);
      checks++;
      if (res !== ref_div(op, a, b) || rtag !== tag) begin
        failures++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d",
                 i, op, a, b, res, rtag, ref_div(op, a, b), tag);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
